uart_time_cmd: RTL and testbench

- Command parser directly upstream of the minute/second digit counter; turns UART receive bytes into the counter's reconfig_l / reconfig_m / reconfig_en load.
- Accepts ASCII frame 'S', tens digit, units digit, CR (0x0D), e.g. "S37\r" loads tens=3, units=7.
- Malformed or stalled frames are dropped and flagged; an optional ack byte goes back toward the UART transmitter.

---
 rtl/uart_time_cmd.sv | 179 +++++++++++++++++
 tb/tb_uart_time_cmd.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_time_cmd.sv
// uart_time_cmd: parses "S<tens><units>\r" UART receive bytes into a digit-counter reload.
// Define UART_TIME_CMD_ECHO_EN to return an ack byte ('K' on load, 'E' on error) to the transmitter.
module uart_time_cmd #(
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter int unsigned MAX_TENS       = 5
) (
  input  logic       clk,
  input  logic       resett,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] reconfig_l,
  output logic [3:0] reconfig_m,
  output logic       reconfig_en,
  output logic       cmd_err,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int unsigned      CNT_W         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX       = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       TENS_MAX_CHAR = 8'(32'h30 + MAX_TENS);

  typedef enum logic [1:0] {
    IDLE,
    GOT_S,
    GOT_TENS,
    GOT_UNITS
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       units_q, units_d;
  logic [3:0]       load_m_q, load_m_d;
  logic [3:0]       load_l_q, load_l_d;
  logic             load_en_q, load_en_d;
  logic             err_q, err_d;

  logic       is_s, is_digit, is_tens, is_cr;
  logic [3:0] digit;

  assign is_s     = (rx_data == 8'h53) || (rx_data == 8'h73);
  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_tens  = (rx_data >= 8'h30) && (rx_data <= TENS_MAX_CHAR);
  assign is_cr    = (rx_data == 8'h0D);
  // ASCII '0'..'9' carry their binary value in the low nibble.
  assign digit    = rx_data[3:0];

  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that leaves one unassigned infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    tens_d    = tens_q;
    units_d   = units_q;
    load_m_d  = load_m_q;
    load_l_d  = load_l_q;
    load_en_d = 1'b0;
    err_d     = 1'b0;

    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (rx_valid) begin
      cnt_d = '0;
      if (is_s) begin
        state_d = GOT_S;
      end else begin
        unique case (state_q)
          IDLE: ;
          GOT_S: begin
            if (is_tens) begin
              tens_d  = digit;
              state_d = GOT_TENS;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
          GOT_TENS: begin
            if (is_digit) begin
              units_d = digit;
              state_d = GOT_UNITS;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
          GOT_UNITS: begin
            if (is_cr) begin
              load_m_d  = tens_q;
              load_l_d  = units_q;
              load_en_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end else if ((state_q != IDLE) && (cnt_q == CNT_LAST)) begin
      // The limit is reached on this edge with no byte: abandon the frame.
      err_d   = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge resett) begin
    if (!resett) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tens_q    <= '0;
      units_q   <= '0;
      load_m_q  <= '0;
      load_l_q  <= '0;
      load_en_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      load_m_q  <= load_m_d;
      load_l_q  <= load_l_d;
      load_en_q <= load_en_d;
      err_q     <= err_d;
    end
  end

  assign reconfig_m  = load_m_q;
  assign reconfig_l  = load_l_q;
  assign reconfig_en = load_en_q;
  assign cmd_err     = err_q;

`ifdef UART_TIME_CMD_ECHO_EN
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;

  // The newest status always wins, even over a byte handed off on the same edge.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (load_en_d) begin
      tx_valid_d = 1'b1;
      tx_data_d  = 8'h4B;
    end else if (err_d) begin
      tx_valid_d = 1'b1;
      tx_data_d  = 8'h45;
    end else if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resett) begin
    if (!resett) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
`else
  logic unused_tx_ready;
  assign unused_tx_ready = tx_ready;
  assign tx_valid        = 1'b0;
  assign tx_data         = 8'h00;
`endif

endmodule

// File: tb/tb_uart_time_cmd.sv
// Randomized scoreboard bench for uart_time_cmd: a frame-level reference model predicts
// load/error events per cycle; a separate monitor compares them against the DUT outputs.
module tb_uart_time_cmd;

  localparam int TO = 16;
  localparam int MT = 5;

  logic       clk = 1'b0;
  logic       resett = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic [3:0] reconfig_l, reconfig_m;
  logic       reconfig_en, cmd_err;
  logic [7:0] tx_data;
  logic       tx_valid;

  uart_time_cmd #(.TIMEOUT_CYCLES(TO), .MAX_TENS(MT)) dut (
    .clk        (clk),
    .resett     (resett),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .reconfig_l (reconfig_l),
    .reconfig_m (reconfig_m),
    .reconfig_en(reconfig_en),
    .cmd_err    (cmd_err),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         load;
    logic [3:0] m;
    logic [3:0] l;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  bit         run = 1'b0;
  bit         rand_ready = 1'b0;
  logic [3:0] hold_m = 4'd0, hold_l = 4'd0;
  logic       ev = 1'b0;
  logic [7:0] ed = 8'h00;
  logic       rdy_q = 1'b0;

  // Reference model: the bytes of the frame collected so far and idle cycles since the last byte.
  logic [7:0] frame[$];
  int         idle = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rdy_q <= tx_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit prefix_ok();
    int n = frame.size();
    int d;
    if (n >= 2) begin
      d = int'(frame[1]) - 48;
      if (d < 0 || d > MT) return 1'b0;
    end
    if (n >= 3) begin
      d = int'(frame[2]) - 48;
      if (d < 0 || d > 9) return 1'b0;
    end
    if (n >= 4 && frame[3] != 8'h0D) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_err(input int at);
    exp_t e;
    e.cyc = at; e.load = 1'b0; e.m = 4'd0; e.l = 4'd0;
    sb.push_back(e);
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input int at);
    exp_t e;
    if (v) begin
      idle = 0;
      if (b == 8'h53 || b == 8'h73) begin
        frame.delete();
        frame.push_back(b);
      end else if (frame.size() != 0) begin
        frame.push_back(b);
        if (!prefix_ok()) begin
          push_err(at);
          frame.delete();
        end else if (frame.size() == 4) begin
          e.cyc = at; e.load = 1'b1;
          e.m = 4'(int'(frame[1]) - 48);
          e.l = 4'(int'(frame[2]) - 48);
          sb.push_back(e);
          frame.delete();
        end
      end
    end else if (frame.size() != 0) begin
      idle++;
      if (idle >= TO) begin
        push_err(at);
        frame.delete();
        idle = 0;
      end
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid = v;
    rx_data  = v ? b : 8'($urandom);
    tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
    model_step(v, b, cyc + 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    drive(1'b1, a); drive(1'b1, b); drive(1'b1, c); drive(1'b1, d);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    #1;
    resett = 1'b0;
    #1;
    check("rst_reconfig_m", reconfig_m, 0);
    check("rst_reconfig_l", reconfig_l, 0);
    check("rst_reconfig_en", reconfig_en, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    frame.delete();
    idle = 0;
    hold_m = 4'd0; hold_l = 4'd0;
    ev = 1'b0; ed = 8'h00;
    #1;
    resett = 1'b1;
  endtask

  // Monitor: pops the event expected on this cycle and compares every output.
  exp_t m_e;
  bit   m_el, m_ee, m_chk_data;
  always @(negedge clk) begin
    if (run && resett) begin
      m_el = 1'b0;
      m_ee = 1'b0;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        m_e = sb.pop_front();
        if (m_e.load) begin
          m_el = 1'b1;
          hold_m = m_e.m;
          hold_l = m_e.l;
        end else begin
          m_ee = 1'b1;
        end
      end
`ifdef UART_TIME_CMD_ECHO_EN
      if (m_el) begin
        ev = 1'b1; ed = 8'h4B;
      end else if (m_ee) begin
        ev = 1'b1; ed = 8'h45;
      end else if (ev && rdy_q) begin
        ev = 1'b0;
      end
      m_chk_data = ev;
`else
      m_chk_data = 1'b1;
`endif
      check("reconfig_en", reconfig_en, m_el);
      check("cmd_err", cmd_err, m_ee);
      check("reconfig_m", reconfig_m, hold_m);
      check("reconfig_l", reconfig_l, hold_l);
      check("tx_valid", tx_valid, ev);
      if (m_chk_data) check("tx_data", tx_data, ed);
    end
  end

  logic [7:0] fr[$];
  logic [7:0] junk[6] = '{8'h0A, 8'h41, 8'h78, 8'h53, 8'h39, 8'h30};
  int         gsel;

  initial begin
    #2;
    check("init_reconfig_m", reconfig_m, 0);
    check("init_reconfig_l", reconfig_l, 0);
    check("init_reconfig_en", reconfig_en, 0);
    check("init_cmd_err", cmd_err, 0);
    check("init_tx_valid", tx_valid, 0);
    check("init_tx_data", tx_data, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    resett = 1'b1;
    run = 1'b1;

    send4("S", "3", "7", 8'h0D);
    idle_cycles(2);
    send4("S", "6", "0", 8'h0D);
    idle_cycles(2);
    drive(1'b1, "S"); drive(1'b1, "1");
    send4("S", "4", "2", 8'h0D);
    idle_cycles(1);
    drive(1'b1, "S"); drive(1'b1, "2");
    idle_cycles(TO + 2);
    send4("S", "5", "9", 8'h0D);
    drive(1'b1, "S"); drive(1'b1, "1"); drive(1'b1, "2");
    pulse_reset();
    drive(1'b1, 8'h0D);
    idle_cycles(2);
    send4("S", "0", "0", 8'h0D);
    drive(1'b1, "S"); drive(1'b1, "x");
    idle_cycles(4);
    rand_ready = 1'b1;

    for (int f = 0; f < 120; f++) begin
      fr = {($urandom_range(0, 3) == 0) ? 8'h73 : 8'h53,
            8'(32'h30 + $urandom_range(0, 7)),
            8'(32'h30 + $urandom_range(0, 9)),
            8'h0D};
      if ($urandom_range(0, 4) == 0) fr[$urandom_range(0, 3)] = junk[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) void'(fr.pop_back());
      foreach (fr[i]) begin
        gsel = int'($urandom_range(0, 19));
        if (gsel >= 14 && gsel <= 17) idle_cycles(gsel - 13);
        else if (gsel == 18) idle_cycles(TO - 1);
        else if (gsel == 19) idle_cycles(TO);
        drive(1'b1, fr[i]);
      end
    end

    idle_cycles(TO + 4);
    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
